jmb_mad2_sched: RTL and testbench
=================================

# jmb_mad2_sched

Round-robin scheduler that shares one `jmb_mad2` multiply-add datapath, `(add_1 + add_2) * mult`, among `NUM_REQ` requesters. Each requester presents an operand triple with a valid/ready handshake. The scheduler grants one requester, registers its operands and computes the result. It then returns the result with the requester's ID on a single response port that has backpressure. Only one operation is in flight at a time; the block sits between the requesting engines and the shared arithmetic unit.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `ID_W`, default 2: response ID width, equal to clog2(`NUM_REQ`).
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: bit i means requester i has an operation pending.
- `req_ready` out `NUM_REQ`: one-hot grant; bit i high means the request is accepted this cycle.
- `req_add_1` in `NUM_REQ`*8: packed, requester i at bits [8i+7:8i].
- `req_add_2` in `NUM_REQ`*8: packed, same layout.
- `req_mult` in `NUM_REQ`*8: packed, same layout.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: consumer accepts the result.
- `rsp_id` out `ID_W`: index of the requester that owns the result.
- `rsp_data` out 32: the result.
- `busy` out 1: high in any state other than IDLE.
- `op_count` out 16: number of completed responses; wraps modulo 2^16.

## Operation
- FSM states: IDLE, CALC, RESP.
- **IDLE**
  - `req_ready` = round-robin one-hot pick among the set `req_valid` bits. The search starts at `last_grant`+1 and wraps from `NUM_REQ`-1 to 0.
  - No valid bits set: `req_ready` = 0 and the FSM stays in IDLE.
  - On a grant: capture that requester's operands into `op_a1`, `op_a2`, `op_m`; capture its index into `cur_id` and `last_grant`; go to CALC.
- **CALC**
  - Feed the registered operands to `jmb_mad2`.
  - Register the result into `rsp_data`; go to RESP.
- **RESP**
  - `rsp_valid` = 1. `rsp_id` = `cur_id`. `rsp_data` is held stable.
  - If `rsp_ready` = 1: `op_count` increments and the FSM goes to IDLE.
  - Otherwise the FSM stays in RESP; all response outputs hold.
- `req_ready` is 0 in CALC and RESP. Requesters hold `req_valid` and operands stable until granted. The scheduler never drops or reorders an accepted request.
- **Arithmetic:** the sum is 9 bits. The product is 17 bits, maximum 510*255 = 130050, zero-extended to 32 bits. No saturation.
- **Fairness:** a requester that keeps `req_valid` asserted is granted within `NUM_REQ` operations. Granting the only valid requester repeatedly is legal.
- **Reset**, from any state including mid-operation:
  - FSM goes to IDLE; any in-flight operation is discarded.
  - `last_grant` = `NUM_REQ`-1, so requester 0 has first priority.
  - `rsp_valid` = 0, `rsp_id` = 0, `rsp_data` = 0, `op_count` = 0, `busy` = 0, `req_ready` = 0.
  - Operand registers are cleared.

## Timing
- The grant handshake completes in cycle T.
- CALC runs in T+1.
- `rsp_valid` rises in T+2.
- With `rsp_ready` held high: IDLE in T+3, next grant possible in T+3. Throughput is 1 operation per 3 cycles.
- Each cycle `rsp_ready` = 0 during RESP adds one cycle of stall.
- `req_ready` is combinational from `req_valid`, state and `last_grant`. No combinational path runs from `rsp_ready` to `req_ready`.
- `rsp_valid`, `rsp_id`, `rsp_data`, `busy` and `op_count` are registered or decoded from state only.
- A `req_valid` set during CALC or RESP waits; it is arbitrated in the next IDLE cycle.

## Structure
- Shared package `jmb_mad2_pkg`:
  - state encoding: IDLE = 2'd0, CALC = 2'd1, RESP = 2'd2;
  - operand width 8, result width 32, counter width 16.
- Sub-module: the existing `jmb_mad2`, instantiated once as the datapath. Its output is registered in CALC.
- Round-robin selection is a function or block inside `jmb_mad2_sched`, not a separate module.

## Test plan
- **Reset:** hold `reset` 2 cycles, no requests -> all outputs 0, `busy` = 0 for 5 cycles.
- **Single request:** requester 0 sends `add_1`=2, `add_2`=3, `mult`=2, `rsp_ready`=1 -> `req_ready`=4'b0001 in T; `rsp_valid`=1, `rsp_id`=0, `rsp_data`=10 in T+2; `op_count`=1.
- **Full contention:** all 4 `req_valid` held high, each requester with distinct operands -> grants in order 0,1,2,3,0. Each `rsp_data` matches (a1+a2)*m. Max operands 255,255,255 -> 130050.
- **Backpressure:** `rsp_ready`=0 for 4 cycles in RESP -> `rsp_valid`, `rsp_id` and `rsp_data` stable; no new `req_ready`; accepted on the 5th cycle; next grant the cycle after.
- **Reset mid-operation:** assert `reset` during CALC -> next cycle IDLE with `rsp_valid`=0. The pending requester 2 is re-granted later; no response is issued for the aborted operation.
- **Counter wrap:** preload via 65536 completed operations, or force `op_count`=16'hFFFF, then complete one -> `op_count`=0.

Source files
------------

// File: rtl/jmb_mad2_pkg.sv
// jmb_mad2_pkg: shared types and widths for the jmb_mad2 multiply-add
// datapath and its round-robin scheduler.
//   state_e : scheduler FSM encoding (IDLE/CALC/RESP)
//   op_t    : one registered operand triple
package jmb_mad2_pkg;

  localparam int OP_W   = 8;   // operand width
  localparam int SUM_W  = 9;   // add_1 + add_2, never overflows
  localparam int PROD_W = 17;  // 510 * 255 = 130050 fits in 17 bits
  localparam int RES_W  = 32;  // result width on the response port
  localparam int CNT_W  = 16;  // completed-operation counter

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef struct packed {
    logic [OP_W-1:0] a1;
    logic [OP_W-1:0] a2;
    logic [OP_W-1:0] m;
  } op_t;

endpackage

// File: rtl/jmb_mad2.sv
// jmb_mad2: combinational multiply-add, result = (add_1 + add_2) * mult.
// Ports:
//   add_1, add_2, mult : OP_W-bit unsigned operands
//   result             : RES_W-bit zero-extended product (no saturation)
module jmb_mad2
  import jmb_mad2_pkg::*;
(
  input  logic [OP_W-1:0]  add_1,
  input  logic [OP_W-1:0]  add_2,
  input  logic [OP_W-1:0]  mult,
  output logic [RES_W-1:0] result
);

  logic [SUM_W-1:0]  sum;
  logic [PROD_W-1:0] prod;

  always_comb begin
    // Widen before the add/multiply so the carry and full product survive.
    sum    = {1'b0, add_1} + {1'b0, add_2};
    prod   = {{(PROD_W-SUM_W){1'b0}}, sum} * {{(PROD_W-OP_W){1'b0}}, mult};
    result = {{(RES_W-PROD_W){1'b0}}, prod};
  end

endmodule

// File: rtl/jmb_mad2_sched.sv
// jmb_mad2_sched: round-robin scheduler sharing one jmb_mad2 datapath
// among NUM_REQ requesters, one operation in flight at a time.
// Ports:
//   clock, reset          : rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   : per-requester handshake, req_ready one-hot grant
//   req_add_1/_2/req_mult : packed operands, requester i at [8i+7:8i]
//   rsp_valid/rsp_ready   : response handshake with backpressure
//   rsp_id, rsp_data      : owner index and (a1+a2)*m result
//   busy                  : FSM not in IDLE
//   op_count              : completed responses, wraps at 2^16
// Timing: grant in T, CALC in T+1, rsp_valid from T+2 until accepted.
module jmb_mad2_sched
  import jmb_mad2_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_add_1,
  input  logic [NUM_REQ*OP_W-1:0] req_add_2,
  input  logic [NUM_REQ*OP_W-1:0] req_mult,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [RES_W-1:0]        rsp_data,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_count
);

  state_e            state_q,      state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   cur_id_q,     cur_id_d;
  op_t               op_q,         op_d;
  logic [RES_W-1:0]  rsp_data_q,   rsp_data_d;
  logic [CNT_W-1:0]  op_count_q,   op_count_d;

  logic [NUM_REQ-1:0] gnt_vec;
  logic [ID_W-1:0]    gnt_idx;
  logic               gnt_any;
  op_t                gnt_op;
  logic [RES_W-1:0]   mad_res;

  // Round-robin pick: scan from last_grant+1 upward, wrapping at NUM_REQ-1,
  // first set req_valid wins. Operands of the winner are muxed out here so
  // the IDLE capture is a plain register load.
  always_comb begin
    int idx;
    gnt_vec = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    gnt_op  = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any      = 1'b1;
        gnt_vec[idx] = 1'b1;
        gnt_idx      = ID_W'(idx);
        gnt_op.a1    = req_add_1[idx*OP_W +: OP_W];
        gnt_op.a2    = req_add_2[idx*OP_W +: OP_W];
        gnt_op.m     = req_mult[idx*OP_W +: OP_W];
      end
    end
  end

  jmb_mad2 u_mad2 (
    .add_1  (op_q.a1),
    .add_2  (op_q.a2),
    .mult   (op_q.m),
    .result (mad_res)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cur_id_d     = cur_id_q;
    op_d         = op_q;
    rsp_data_d   = rsp_data_q;
    op_count_d   = op_count_q;
    req_ready    = '0;
    unique case (state_q)
      IDLE: begin
        // A grant shown during reset would be lost by the requester, so
        // hold it off; everything else is a pure function of req_valid.
        if (!reset) req_ready = gnt_vec;
        if (gnt_any) begin
          state_d      = CALC;
          last_grant_d = gnt_idx;
          cur_id_d     = gnt_idx;
          op_d         = gnt_op;
        end
      end
      CALC: begin
        rsp_data_d = mad_res;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      cur_id_q     <= '0;
      op_q         <= '0;
      rsp_data_q   <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cur_id_q     <= cur_id_d;
      op_q         <= op_d;
      rsp_data_q   <= rsp_data_d;
      op_count_q   <= op_count_d;
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = cur_id_q;
  assign rsp_data  = rsp_data_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_jmb_mad2_sched.sv
module tb_jmb_mad2_sched;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*8-1:0]  req_add_1 = '0, req_add_2 = '0, req_mult = '0;
  logic                  rsp_valid;
  logic                  rsp_ready = 1'b0;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  busy;
  logic [15:0]           op_count;

  always #5 clock = ~clock;

  jmb_mad2_sched #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_add_1(req_add_1), .req_add_2(req_add_2), .req_mult(req_mult),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .op_count(op_count)
  );

  typedef struct { int id; int data; } exp_t;

  int   n_cmp = 0, n_bad = 0;
  bit   pend [NUM_REQ];
  int   a1 [NUM_REQ], a2 [NUM_REQ], mm [NUM_REQ];
  exp_t sb [$];      // accepted, not yet answered
  int   gq [$];      // grant history
  int   last = NUM_REQ - 1, age = 0, cnt = 0, stall = 0, gen_pct = 0;
  bit   rnd_rdy = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Next requester by the round-robin rule: first pending after the last grant.
  function automatic int rr_pick();
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i = (last + k) % NUM_REQ;
      if (pend[i]) return i;
    end
    return -1;
  endfunction

  task automatic new_op(input int i);
    pend[i] = 1'b1;
    a1[i] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
    a2[i] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
    mm[i] = ($urandom_range(0, 7) == 0) ? 255 : int'($urandom_range(0, 255));
  endtask

  task automatic set_op(input int i, input int x, input int y, input int z);
    pend[i] = 1'b1; a1[i] = x; a2[i] = y; mm[i] = z;
  endtask

  task automatic drive();
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]        = pend[i];
      req_add_1[i*8 +: 8] = 8'(a1[i]);
      req_add_2[i*8 +: 8] = 8'(a2[i]);
      req_mult[i*8 +: 8]  = 8'(mm[i]);
    end
    rsp_ready = (stall > 0) ? 1'b0 : (rnd_rdy ? ($urandom_range(0, 3) != 0) : 1'b1);
  endtask

  // One clock: check outputs at negedge against the model, advance the model
  // to what the coming edge should do, then drive new inputs after the edge.
  task automatic step();
    int g;
    bit in_resp;
    @(negedge clock);
    g       = (!reset && sb.size() == 0) ? rr_pick() : -1;
    in_resp = (sb.size() > 0) && (age >= 2);
    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("rsp_valid", 32'(rsp_valid), 32'(in_resp));
    chk("busy", 32'(busy), 32'(sb.size() > 0));
    chk("op_count", 32'(op_count), 32'(cnt));
    if (in_resp) begin
      chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
      chk("rsp_data", rsp_data, 32'(sb[0].data));
    end
    if (reset) begin
      if (sb.size() > 0) pend[sb[0].id] = 1'b1;  // aborted op is presented again
      sb.delete();
      last = NUM_REQ - 1; cnt = 0; age = 0;
    end else if (g >= 0) begin
      sb.push_back('{id: g, data: (a1[g] + a2[g]) * mm[g]});
      gq.push_back(g);
      pend[g] = 1'b0; last = g; age = 1;
    end else if (in_resp) begin
      if (rsp_ready) begin
        void'(sb.pop_front());
        cnt = (cnt + 1) % 65536;
      end else if (stall > 0) stall--;
    end else if (sb.size() > 0) age++;
    @(posedge clock); #1;
    for (int i = 0; i < NUM_REQ; i++)
      if (!pend[i] && int'($urandom_range(0, 99)) < gen_pct) new_op(i);
    drive();
  endtask

  task automatic drain();
    int k;
    bit any;
    k = 0;
    any = 1'b1;
    while (any && k < 200) begin
      any = sb.size() > 0;
      for (int i = 0; i < NUM_REQ; i++) any |= pend[i];
      if (any) step();
      k++;
    end
    chk("drain_done", 32'(any), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; a1[i] = 0; a2[i] = 0; mm[i] = 0;
    end
    // reset and quiet idle
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    drive();
    for (int c = 0; c < 5; c++) begin
      step();
      chk("rst_rsp_id", 32'(rsp_id), 32'd0);
      chk("rst_rsp_data", rsp_data, 32'd0);
    end

    // single request from requester 0
    set_op(0, 2, 3, 2);
    drive();
    step();
    step();
    chk("single_data", rsp_data, 32'd10);
    step();
    step();
    chk("single_count", 32'(op_count), 32'd1);

    // backpressure: 4 stalled RESP cycles, competing request waits
    set_op(1, 7, 9, 11);
    stall = 4;
    drive();
    step();
    set_op(2, 1, 1, 1);
    drive();
    repeat (10) step();
    chk("bp_stall_used", 32'(stall), 32'd0);
    drain();

    // full contention right after reset: 0,1,2,3,0
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    set_op(0, 10, 20, 3);
    set_op(1, 11, 21, 4);
    set_op(2, 12, 22, 5);
    set_op(3, 255, 255, 255);
    gen_pct = 100;
    gq.delete();
    drive();
    repeat (16) step();
    gen_pct = 0;
    chk("cont_grants", 32'(gq.size() >= 5), 32'd1);
    if (gq.size() >= 5) begin
      chk("cont_g0", 32'(gq[0]), 32'd0);
      chk("cont_g1", 32'(gq[1]), 32'd1);
      chk("cont_g2", 32'(gq[2]), 32'd2);
      chk("cont_g3", 32'(gq[3]), 32'd3);
      chk("cont_g4", 32'(gq[4]), 32'd0);
    end
    drain();

    // reset while in CALC: no response, requester 2 granted again
    set_op(2, 100, 50, 7);
    drive();
    step();                 // grant
    reset = 1'b1;
    step();                 // CALC cycle sees reset
    reset = 1'b0;
    drive();
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    gq.delete();
    repeat (5) step();
    chk("abort_regrant", 32'(gq.size() > 0 ? gq[0] : -1), 32'd2);
    drain();

    // counter wrap: preload 0xFFFF during an idle cycle, then complete one
    @(negedge clock);
    force dut.op_count_d = 16'hFFFF;
    @(posedge clock); #1;
    release dut.op_count_d;
    cnt = 65535;
    chk("preload", 32'(op_count), 32'hFFFF);
    set_op(3, 255, 255, 255);
    drive();
    repeat (4) step();
    chk("wrap", 32'(op_count), 32'd0);

    // randomized traffic with random backpressure
    rnd_rdy = 1'b1;
    gen_pct = 40;
    repeat (400) step();
    gen_pct = 0;
    rnd_rdy = 1'b0;
    drive();
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
